// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern sequence controller: state encoding,
// default sizing constants and the length-field width derivation.
package pattern_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Length field must hold the value MAX_LEN itself, hence the +1.
    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/pattern_shift_match.sv
// Serial history shift register with fill tracking and a length-masked
// compare against the loaded pattern. The hit output is combinational and
// looks at the incoming bit, so the controller can register the match on
// the same edge that shifts the completing bit in.
module pattern_shift_match
    import pattern_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = len_width(MAX_LEN_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               overlap,
    input  logic               data_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_inc;

    // Next history view, active-length mask and saturating fill lookahead.
    always_comb begin
        hist_nxt = {hist_q[MAX_LEN-2:0], data_in};
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        fill_inc = (fill_q >= len) ? len : fill_q + LEN_W'(1);
        hit      = shift_en && (len != '0) && (fill_inc >= len) &&
                   (((hist_nxt ^ pattern) & mask) == '0);
    end

    // Fill counter; a non-overlapping match restarts the count from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= '0;
        end else if (clr) begin
            fill_q <= '0;
        end else if (shift_en) begin
            fill_q <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

    // History is pure data; it is cleared on run entry rather than by reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            hist_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_nxt;
        end
    end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Programmable serial pattern-detection controller. Accepts a pattern
// configuration over a valid/ready handshake, runs a shift-register matcher
// over the qualified serial stream, counts matches and reports completion.
// Optional build macro PATTERN_SEQ_CTRL_TIMEOUT_EN adds a RUN-state
// inactivity timeout (parameter TO_CYCLES, output timeout).
module pattern_seq_ctrl
    import pattern_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int LEN_W   = len_width(MAX_LEN)
`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               pattern_det,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               done
);

    state_e             state_q, state_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;

    logic               cfg_accept;
    logic               len_ok;
    logic               start_go;
    logic               shift_en;
    logic               hit;

`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    assign cfg_ready   = (state_q != ST_RUN);
    assign cfg_accept  = cfg_valid && cfg_ready;
    assign len_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // A same-cycle configuration wins over start.
    assign start_go    = start && loaded_q && cfg_ready && !cfg_accept;
    // Abort suppresses the shift so a coinciding completing bit never matches.
    assign shift_en    = (state_q == ST_RUN) && data_valid && !abort;
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    assign cfg_err     = err_q;
    assign pattern_det = det_q;
    assign match_cnt   = cnt_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
    assign timeout     = timeout_q;
`endif

    pattern_shift_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (start_go),
        .overlap  (ovl_q),
        .data_in  (data_in),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    // Next-state logic for the FSM, handshake flags and match counter.
    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        err_d    = 1'b0;
        det_d    = 1'b0;
        cnt_d    = cnt_q;
`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
`endif
        if (cfg_accept) begin
            if (len_ok) begin
                loaded_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_go) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    det_d = 1'b1;
                    cnt_d = cnt_inc;
                    if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                        state_d = ST_DONE;
                    end
`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            det_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            det_q    <= det_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef PATTERN_SEQ_CTRL_TIMEOUT_EN
    // Inactivity counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // Configuration fields are data; the loaded flag alone marks validity.
    always_ff @(posedge clk) begin
        if (cfg_accept && len_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
        end
    end

endmodule

// File: doc/pattern_seq_ctrl.md
# pattern_seq_ctrl

Programmable serial pattern-detection controller for the dynamic pattern detector path. It accepts a runtime pattern configuration (bits, length, overlap mode, match target) through a valid/ready handshake. It arms and runs a shift-register matcher over a qualified 1-bit serial stream, counts matches, and reports completion. It sits between the host/config logic and the serial data source, replacing hard-coded per-pattern FSMs.

## Interface
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 8: match counter / target width.
- LEN_W, $clog2(MAX_LEN)+1: width of length field (derived).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  controller can accept configuration (IDLE or DONE).
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CNT_W  matches required for DONE; 0 = run until abort.
- cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected.
- start  in  1  begin a run with the loaded configuration.
- abort  in  1  stop a run.
- data_valid  in  1  data_in qualified this cycle.
- data_in  in  1  serial data bit.
- pattern_det  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  matches in current/last run.
- busy  out  1  high in RUN.
- done  out  1  level, high in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE. No configuration is loaded after reset.
- Reset values: cfg_ready=1, cfg_err=0, pattern_det=0, match_cnt=0, busy=0, done=0. Timeout output is 0 when compiled in.
- Config accept: cfg_valid&&cfg_ready.
  - Legal cfg_len: latch all cfg_* fields and set the loaded flag.
  - cfg_len=0 or >MAX_LEN: keep the previous config and pulse cfg_err.
- IDLE/DONE: start with the loaded flag set goes to RUN. On entry, clear history, fill count, match_cnt and done.
- start without a loaded config is ignored.
- cfg accept and start in the same cycle: config is taken and start is ignored.
- RUN: each data_valid cycle shifts data_in into history at the LSB. The fill count increments, saturating at len.
  - Match condition: fill ≥ len and history[len-1:0] == pattern[len-1:0].
  - On a match: pattern_det=1 next cycle and match_cnt+1, saturating at all-ones.
  - If overlap=0, also clear the fill count so the next match needs len fresh bits.
  - data_valid=0 means no shift and no match evaluation.
- Match raising match_cnt to cfg_target (target≠0) goes to DONE.
- abort in RUN goes to IDLE. match_cnt is retained. abort has priority over a same-cycle match: no pattern_det and no count.
- abort outside RUN is ignored. start in RUN is ignored.
- Asynchronous reset mid-run returns to IDLE and clears the loaded config.

## Timing
- pattern_det, match_cnt update, and the RUN→DONE transition all occur on the same edge: the edge after the sampling of the completing bit.
- cfg_err is asserted on the edge after the rejected handshake.
- busy asserts one edge after start.
- The first data bit is sampled on the first RUN cycle.
- Throughput: one bit per cycle. Back-to-back overlapping matches yield consecutive pattern_det pulses (for example, len 1).

## Configuration
- PATTERN_SEQ_CTRL_TIMEOUT_EN defined:
  - Adds parameter TO_CYCLES (default 1024) and output timeout (level).
  - In RUN, a counter counts cycles since the last match or since entry.
  - Reaching TO_CYCLES goes to DONE with timeout=1.
  - timeout clears on the next start.
- Not defined: no timeout port or counter. RUN exits only on target or abort.

## Structure
- Shared package pattern_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the LEN_W derivation function;
  - default MAX_LEN/CNT_W constants.
- Sub-module pattern_shift_match holds:
  - the history shift register;
  - the fill counter;
  - the masked length compare.
- Inputs to pattern_shift_match: shift enable, clear, pattern, len. Output: a combinational hit.
- The controller FSM, counters and handshake live in the top level.

## Test plan
- Pattern 1011, len 4, overlap=1, target 0; bits 1,0,1,1,0,1,1 with data_valid always 1 → pattern_det after bits 4 and 7; match_cnt=2; done=0.
- Same stream with overlap=0 → single pattern_det after bit 4; match_cnt=1.
- Pattern 1011, target 2, stream 1011 1011 with data_valid gaps (a 0 cycle every other bit) → matches unaffected by gaps; DONE after the second match; done=1; busy=0; cfg_ready=1.
- Config errors:
  - cfg_len=0 → cfg_err pulse; the previous config is still used by the next start.
  - start before any config → stays IDLE.
- Abort during RUN after 1 match, with abort coinciding with a completing bit → IDLE; match_cnt=1; no pattern_det.
- rst low mid-run, asynchronously between edges → all outputs at reset values immediately; start ignored until re-config.
  - With PATTERN_SEQ_CTRL_TIMEOUT_EN, TO_CYCLES=16 and no matches → DONE with timeout=1 after 16 RUN cycles.
